// File: rtl/alu_pkg.sv
// alu_pkg: shared op/state encodings and op classification for the execute-stage ALU
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, SHIFT, MUL} alu_state_e;
  function automatic logic is_multicycle(alu_op_e op);
    return op inside {ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL};
  endfunction
endpackage

// File: rtl/alu_iter_unit.sv
// alu_iter_unit: iterative shift / shift-add multiply datapath with step counter
//   i_start loads operands; while i_busy && !i_stall one step per cycle.
//   o_done flags that this cycle's step is the last; o_result is its outcome.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter int MUL_STEP   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  alu_op_e         i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_busy,
  input  logic            i_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  localparam int SW = $clog2(XLEN);
  localparam int SS = (SHIFT_STEP == 0) ? 1 : SHIFT_STEP;
  localparam logic [SW:0] SSV = (SW+1)'(SS);
  alu_op_e r_op;
  logic [XLEN-1:0] r_val, r_acc, r_mpl;
  logic [SW-1:0] r_cnt, w_step;
  logic [XLEN-1:0] w_sra, w_sh, w_pp, w_acc_n, w_mpl_n;
  logic w_mul;
  assign w_mul   = r_op == ALU_MUL;
  assign w_step  = ({1'b0, r_cnt} < SSV) ? r_cnt : SSV[SW-1:0];
  // kept separate so the arithmetic shift is not made unsigned by the mux
  assign w_sra   = $signed(r_val) >>> w_step;
  assign w_sh    = (r_op == ALU_SLL) ? r_val << w_step : (r_op == ALU_SRL) ? r_val >> w_step : w_sra;
  assign w_mpl_n = r_mpl >> MUL_STEP;
  assign w_acc_n = r_acc + w_pp;
  // multiply finishes early once no set multiplier bits remain beyond this step
  assign o_done   = i_busy && (w_mul ? w_mpl_n == '0 : {1'b0, r_cnt} <= SSV);
  assign o_result = w_mul ? w_acc_n : w_sh;
  always_comb begin
    w_pp = '0;
    for (int k = 0; k < MUL_STEP; k++) w_pp = w_pp + ({XLEN{r_mpl[k]}} & (r_val << k));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_op  <= ALU_NONE;
      r_val <= '0;
      r_acc <= '0;
      r_mpl <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_op  <= i_op;
      r_val <= i_a;
      r_acc <= '0;
      r_mpl <= i_b;
      r_cnt <= i_b[SW-1:0];
    end else if (i_busy && !i_stall) begin
      r_val <= w_mul ? r_val << MUL_STEP : w_sh;
      r_acc <= w_acc_n;
      r_mpl <= w_mpl_n;
      r_cnt <= r_cnt - w_step;
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage RV32I ALU with multi-cycle shift/mul and registered output
//   in_*  : valid/ready operation input (op, operands, rd, wr_en)
//   out_* : one-entry result register toward writeback (valid/ready)
//   flush : drops in-flight op and pending result; busy: multi-cycle op running
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter int MUL_STEP   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_rd,
  input  logic            in_wr_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_wr_en,
  output logic            busy
);
  localparam int SW = $clog2(XLEN);
  alu_state_e r_state;
  logic r_out_valid, r_out_wr_en, r_p_wr_en;
  logic [XLEN-1:0] r_out_result;
  logic [4:0] r_out_rd, r_p_rd;
  alu_op_e w_op;
  logic [SW-1:0] w_shamt;
  logic [XLEN-1:0] w_sra, w_alu, w_iter_res;
  logic w_can_out, w_acc, w_multi, w_iter_done, w_fin, w_ld;
  assign w_op      = alu_op_e'(in_op);
  assign w_shamt   = in_b[SW-1:0];
  assign w_can_out = !r_out_valid || out_ready;
  assign in_ready  = !reset && r_state == IDLE && !flush && w_can_out;
  assign w_acc     = in_valid && in_ready;
  // zero-distance shifts (or barrel mode) complete in the acceptance cycle
  assign w_multi   = is_multicycle(w_op) && (w_op == ALU_MUL || (SHIFT_STEP != 0 && w_shamt != '0));
  assign w_fin     = w_iter_done && w_can_out;
  assign w_ld      = w_fin || (w_acc && !w_multi && w_op != ALU_NONE);
  assign w_sra     = $signed(in_a) >>> w_shamt;
  assign w_alu = (w_op == ALU_ADD)  ? in_a + in_b :
                 (w_op == ALU_SUB)  ? in_a - in_b :
                 (w_op == ALU_SLT)  ? {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)} :
                 (w_op == ALU_SLTU) ? {{(XLEN-1){1'b0}}, in_a < in_b} :
                 (w_op == ALU_XOR)  ? in_a ^ in_b :
                 (w_op == ALU_OR)   ? in_a | in_b :
                 (w_op == ALU_AND)  ? in_a & in_b :
                 (w_op == ALU_SLL)  ? in_a << w_shamt :
                 (w_op == ALU_SRL)  ? in_a >> w_shamt :
                 (w_op == ALU_SRA)  ? w_sra : '0;
  alu_iter_unit #(.XLEN(XLEN), .SHIFT_STEP(SHIFT_STEP), .MUL_STEP(MUL_STEP)) u_iter (
    .clk(clk), .reset(reset), .i_start(w_acc && w_multi), .i_op(w_op), .i_a(in_a), .i_b(in_b),
    .i_busy(r_state != IDLE), .i_stall(!w_can_out), .o_done(w_iter_done), .o_result(w_iter_res)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state      <= IDLE;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_rd     <= '0;
      r_out_wr_en  <= 1'b0;
      r_p_rd       <= '0;
      r_p_wr_en    <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out_wr_en <= 1'b0;
    end else begin
      r_out_valid <= (r_out_valid && !out_ready) || w_ld;
      if (w_acc) begin
        r_p_rd    <= in_rd;
        r_p_wr_en <= in_wr_en;
      end
      if (w_acc && w_multi) r_state <= (w_op == ALU_MUL) ? MUL : SHIFT;
      if (w_fin) r_state <= IDLE;
      if (w_ld) begin
        r_out_result <= w_fin ? w_iter_res : w_alu;
        r_out_rd     <= w_fin ? r_p_rd : in_rd;
        r_out_wr_en  <= w_fin ? r_p_wr_en : in_wr_en;
      end
    end
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_rd     = r_out_rd;
  assign out_wr_en  = r_out_wr_en;
  assign busy       = r_state != IDLE;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
  import alu_pkg::*;
  logic clk, reset, flush, in_valid, in_ready, in_wr_en, out_valid, out_ready, out_wr_en, busy;
  logic [3:0] in_op;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0] in_rd, out_rd;
  int total = 0, bad = 0;
  int lat, bz;
  logic [31:0] res;
  logic [4:0] ord;
  typedef struct {logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] r;} vec_t;
  vec_t v[10];
  alu_exec_unit dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int l, output int bc,
                        output logic [31:0] r, output logic [4:0] o);
    int w = 0;
    in_op = op; in_a = a; in_b = b; in_rd = rd; in_wr_en = 1'b1; in_valid = 1'b1;
    while (!in_ready && w < 50) begin tick; w++; end
    tick;
    in_valid = 1'b0;
    l = 1; bc = 0;
    while (!out_valid && l < 100) begin bc += int'(busy); tick; l++; end
    r = out_result; o = out_rd;
  endtask
  initial begin
    v = '{'{ALU_ADD, 32'hFFFFFFFF, 32'h1, 32'h0},
          '{ALU_SLT, 32'hFFFFFFFF, 32'h1, 32'h1},
          '{ALU_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0},
          '{ALU_SUB, 32'h5, 32'h7, 32'hFFFFFFFE},
          '{ALU_XOR, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5},
          '{ALU_OR, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0},
          '{ALU_AND, 32'h12345678, 32'h0000FFFF, 32'h00005678},
          '{ALU_SLT, 32'h1, 32'hFFFFFFFF, 32'h0},
          '{ALU_SLTU, 32'h1, 32'hFFFFFFFF, 32'h1},
          '{ALU_SLL, 32'h1234, 32'h20, 32'h1234}};
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    in_rd = '0; in_wr_en = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_result", out_result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick;
    check("idle_in_ready", {31'b0, in_ready}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      in_op = v[i].op; in_a = v[i].a; in_b = v[i].b; in_rd = 5'(i + 5); in_wr_en = 1'b1; in_valid = 1'b1;
      check("b2b_ready", {31'b0, in_ready}, 32'h1);
      tick;
      check("b2b_valid", {31'b0, out_valid}, 32'h1);
      check("b2b_result", out_result, v[i].r);
      check("b2b_rd", {27'b0, out_rd}, 32'(i + 5));
    end
    in_valid = 1'b0;
    tick;
    check("drain_valid", {31'b0, out_valid}, 32'h0);
    in_op = ALU_NONE; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("none_valid", {31'b0, out_valid}, 32'h0);
    check("none_busy", {31'b0, busy}, 32'h0);
    run_op(ALU_SRA, 32'h80000000, 32'h3F, 5'd9, lat, bz, res, ord);
    check("sra31_lat", lat, 32);
    check("sra31_busy", bz, 31);
    check("sra31_res", res, 32'hFFFFFFFF);
    check("sra31_rd", {27'b0, ord}, 32'd9);
    tick;
    run_op(ALU_SLL, 32'h1, 32'h4, 5'd1, lat, bz, res, ord);
    check("sll4_lat", lat, 5);
    check("sll4_res", res, 32'h10);
    tick;
    run_op(ALU_SRL, 32'h80000000, 32'h24, 5'd2, lat, bz, res, ord);
    check("srl4_lat", lat, 5);
    check("srl4_res", res, 32'h08000000);
    tick;
    run_op(ALU_MUL, 32'd7, 32'd6, 5'd3, lat, bz, res, ord);
    check("mul76_lat", lat, 4);
    check("mul76_res", res, 32'd42);
    tick;
    run_op(ALU_MUL, 32'h10000, 32'h10000, 5'd3, lat, bz, res, ord);
    check("mulbig_lat", lat, 18);
    check("mulbig_res", res, 32'h0);
    tick;
    run_op(ALU_MUL, 32'h1234, 32'h0, 5'd3, lat, bz, res, ord);
    check("mul0_lat", lat, 2);
    check("mul0_res", res, 32'h0);
    tick;
    run_op(ALU_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, lat, bz, res, ord);
    check("mulmax_lat", lat, 33);
    check("mulmax_res", res, 32'h1);
    tick;
    out_ready = 1'b0;
    in_op = ALU_ADD; in_a = 32'd3; in_b = 32'd4; in_rd = 5'd7; in_wr_en = 1'b1; in_valid = 1'b1;
    tick;
    check("hold_add_res", out_result, 32'd7);
    in_op = ALU_XOR; in_a = 32'hF0; in_b = 32'hFF; in_rd = 5'd8;
    check("hold_in_ready", {31'b0, in_ready}, 32'h0);
    tick;
    check("hold_valid", {31'b0, out_valid}, 32'h1);
    check("hold_res", out_result, 32'd7);
    check("hold_rd", {27'b0, out_rd}, 32'd7);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'b0, in_ready}, 32'h1);
    tick;
    in_valid = 1'b0;
    check("xor_valid", {31'b0, out_valid}, 32'h1);
    check("xor_res", out_result, 32'h0F);
    check("xor_rd", {27'b0, out_rd}, 32'd8);
    tick;
    check("xor_drain", {31'b0, out_valid}, 32'h0);
    in_op = ALU_MUL; in_a = 32'd3; in_b = 32'hFFFF; in_rd = 5'd2; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (3) tick;
    check("fl_busy_before", {31'b0, busy}, 32'h1);
    flush = 1'b1; in_op = ALU_ADD; in_a = 32'd1; in_b = 32'd1; in_rd = 5'd9; in_valid = 1'b1;
    #1;
    check("fl_in_ready", {31'b0, in_ready}, 32'h0);
    tick;
    flush = 1'b0; in_valid = 1'b0;
    check("fl_busy", {31'b0, busy}, 32'h0);
    check("fl_valid", {31'b0, out_valid}, 32'h0);
    repeat (20) tick;
    check("fl_valid_later", {31'b0, out_valid}, 32'h0);
    out_ready = 1'b0;
    in_op = ALU_ADD; in_a = 32'd1; in_b = 32'd1; in_rd = 5'd3; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("flo_valid", {31'b0, out_valid}, 32'h1);
    check("flo_res", out_result, 32'd2);
    flush = 1'b1;
    tick;
    flush = 1'b0; out_ready = 1'b1;
    check("flo_cleared", {31'b0, out_valid}, 32'h0);
    check("flo_wr_en", {31'b0, out_wr_en}, 32'h0);
    in_op = ALU_SRA; in_a = 32'h80000000; in_b = 32'd20; in_rd = 5'd6; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (5) tick;
    check("rs_busy_before", {31'b0, busy}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("rs_busy", {31'b0, busy}, 32'h0);
    check("rs_valid", {31'b0, out_valid}, 32'h0);
    check("rs_result", out_result, 32'h0);
    check("rs_rd", {27'b0, out_rd}, 32'h0);
    check("rs_in_ready", {31'b0, in_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick;
    run_op(ALU_ADD, 32'd2, 32'd3, 5'd11, lat, bz, res, ord);
    check("post_rs_lat", lat, 1);
    check("post_rs_res", res, 32'd5);
    check("post_rs_rd", {27'b0, ord}, 32'd11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
